ucsbece154_icache: RTL and testbench

Set-associative, read-only instruction cache between the fetch stage and the burst-mode instruction memory. Fetch hits return the instruction combinationally in the same cycle. A miss stalls fetch, issues a one-cycle read request for the block-aligned line, and fills the line from the memory's `BLOCK_WORDS`-beat burst. It then presents the requested word for one cycle.

---
 rtl/ucsbece154_icache_pkg.sv | 61 ++++++
 rtl/ucsbece154_icache_way.sv | 64 ++++++
 rtl/ucsbece154_icache.sv | 209 ++++++++++++++++++++
 tb/tb_ucsbece154_icache.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154_icache_pkg.sv
// Shared definitions for the instruction cache.
// - Miss-handling FSM state type.
// - Default geometry and field-width helpers.
// - Address-field extract/compose functions.
// Byte address layout, LSB first: byte[1:0] | offset | index | tag.
package ucsbece154_icache_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_SETS    = 8;
  localparam int unsigned DEF_NUM_WAYS    = 4;
  localparam int unsigned DEF_BLOCK_WORDS = 4;

  function automatic int unsigned offset_w(input int unsigned block_words);
    return $clog2(block_words);
  endfunction

  function automatic int unsigned index_w(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned block_words,
                                        input int unsigned num_sets);
    return 32 - 2 - offset_w(block_words) - index_w(num_sets);
  endfunction

  // Way pointers keep at least one bit so a direct-mapped build still elaborates.
  function automatic int unsigned way_w(input int unsigned num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

  localparam int unsigned OFFSET_W = offset_w(DEF_BLOCK_WORDS);
  localparam int unsigned INDEX_W  = index_w(DEF_NUM_SETS);
  localparam int unsigned TAG_W    = tag_w(DEF_BLOCK_WORDS, DEF_NUM_SETS);

  function automatic logic [31:0] addr_offset(input logic [31:0] a, input int unsigned ow);
    return (a >> 2) & ((32'd1 << ow) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int unsigned ow,
                                             input int unsigned iw);
    return (a >> (2 + ow)) & ((32'd1 << iw) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned ow,
                                           input int unsigned iw);
    return a >> (2 + ow + iw);
  endfunction

  // Line base address: offset and byte bits forced to zero.
  function automatic logic [31:0] line_base(input logic [31:0] tag, input logic [31:0] index,
                                            input int unsigned ow, input int unsigned iw);
    return (tag << (2 + ow + iw)) | (index << (2 + ow));
  endfunction

endpackage

// File: rtl/ucsbece154_icache_way.sv
// One cache way: valid bits, tags and data words for every set.
// Ports:
//   clk, reset            clock, async active-high reset (clears valid bits only)
//   rd_index/rd_tag/rd_offset  lookup address fields
//   rd_valid, rd_hit, rd_word  combinational lookup results
//   wr_index, wr_offset   fill target set / word
//   wr_en, wr_data        write one data word
//   commit, commit_tag    write tag and set valid (final fill beat)
//   invalidate            clear valid for wr_index (start of a refill)
module ucsbece154_icache_way
  import ucsbece154_icache_pkg::*;
#(
  parameter int unsigned NUM_SETS    = DEF_NUM_SETS,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int unsigned OFF_W       = OFFSET_W,
  parameter int unsigned IDX_W       = INDEX_W,
  parameter int unsigned TG_W        = TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [TG_W-1:0]  rd_tag,
  input  logic [OFF_W-1:0] rd_offset,
  output logic             rd_valid,
  output logic             rd_hit,
  output logic [31:0]      rd_word,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic             wr_en,
  input  logic [31:0]      wr_data,
  input  logic             commit,
  input  logic [TG_W-1:0]  commit_tag,
  input  logic             invalidate
);

  logic [NUM_SETS-1:0] valid;
  logic [TG_W-1:0]     tags [NUM_SETS];
  logic [31:0]         data [NUM_SETS][BLOCK_WORDS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (invalidate) begin
      valid[wr_index] <= 1'b0;
    end else if (commit) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage need no reset: the valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data[wr_index][wr_offset] <= wr_data;
    end
    if (commit) begin
      tags[wr_index] <= commit_tag;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_hit   = valid[rd_index] && (tags[rd_index] == rd_tag);
  assign rd_word  = data[rd_index][rd_offset];

endmodule

// File: rtl/ucsbece154_icache.sv
// Set-associative read-only instruction cache.
// Hits return the word combinationally; misses stall fetch, request the
// block-aligned line from burst memory, fill it, then present the requested
// word for one cycle.
// Ports:
//   clk, reset                    clock, async active-high reset
//   ReadEnable, ReadAddress       fetch request
//   Instruction, Ready, Busy      fetch response / stall
//   MemReadRequest, MemReadAddress  one-cycle burst start, line base address
//   MemDataIn, MemDataReady       burst beats, offset order 0..BLOCK_WORDS-1
module ucsbece154_icache
  import ucsbece154_icache_pkg::*;
#(
  parameter int unsigned NUM_SETS    = DEF_NUM_SETS,
  parameter int unsigned NUM_WAYS    = DEF_NUM_WAYS,
  parameter int unsigned BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReadEnable,
  input  logic [31:0] ReadAddress,
  output logic [31:0] Instruction,
  output logic        Ready,
  output logic        Busy,
  output logic        MemReadRequest,
  output logic [31:0] MemReadAddress,
  input  logic [31:0] MemDataIn,
  input  logic        MemDataReady
);

  localparam int unsigned OFF_W = offset_w(BLOCK_WORDS);
  localparam int unsigned IDX_W = index_w(NUM_SETS);
  localparam int unsigned TG_W  = tag_w(BLOCK_WORDS, NUM_SETS);
  localparam int unsigned WAY_W = way_w(NUM_WAYS);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);

  state_t state, state_next;

  logic [TG_W-1:0]  lat_tag;
  logic [IDX_W-1:0] lat_index;
  logic [OFF_W-1:0] lat_offset;
  logic [WAY_W-1:0] victim;
  logic             victim_by_ptr;
  logic [OFF_W-1:0] beat_cnt;
  logic [31:0]      crit_word;
  logic [WAY_W-1:0] rr_ptr [NUM_SETS];

  logic [TG_W-1:0]  req_tag;
  logic [IDX_W-1:0] req_index;
  logic [OFF_W-1:0] req_offset;

  logic [NUM_WAYS-1:0] way_valid;
  logic [NUM_WAYS-1:0] way_hit;
  logic [31:0]         way_word [NUM_WAYS];

  logic             hit_any;
  logic [31:0]      hit_word;
  logic [WAY_W-1:0] victim_sel;
  logic             sel_by_ptr;
  logic             lookup_en;
  logic             miss_latch;
  logic             invalidate;
  logic             fill_beat;
  logic             fill_last;

  assign req_tag    = TG_W'(addr_tag(ReadAddress, OFF_W, IDX_W));
  assign req_index  = IDX_W'(addr_index(ReadAddress, OFF_W, IDX_W));
  assign req_offset = OFF_W'(addr_offset(ReadAddress, OFF_W));

  // Lookup only in IDLE, and never while reset is held, so every output is
  // zero during reset even if fetch keeps ReadEnable high.
  assign lookup_en = ReadEnable && !reset && (state == S_IDLE);

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    ucsbece154_icache_way #(
      .NUM_SETS    (NUM_SETS),
      .BLOCK_WORDS (BLOCK_WORDS),
      .OFF_W       (OFF_W),
      .IDX_W       (IDX_W),
      .TG_W        (TG_W)
    ) u_way (
      .clk        (clk),
      .reset      (reset),
      .rd_index   (req_index),
      .rd_tag     (req_tag),
      .rd_offset  (req_offset),
      .rd_valid   (way_valid[w]),
      .rd_hit     (way_hit[w]),
      .rd_word    (way_word[w]),
      .wr_index   (lat_index),
      .wr_offset  (beat_cnt),
      .wr_en      (fill_beat && (victim == WAY_W'(w))),
      .wr_data    (MemDataIn),
      .commit     (fill_last && (victim == WAY_W'(w))),
      .commit_tag (lat_tag),
      .invalidate (invalidate && (victim == WAY_W'(w)))
    );
  end

  always_comb begin
    hit_any  = 1'b0;
    hit_word = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (way_hit[w]) begin
        hit_any  = 1'b1;
        hit_word = way_word[w];
      end
    end
  end

  // Lowest-numbered invalid way wins; the round-robin pointer is used only
  // when the whole set is valid.
  always_comb begin
    victim_sel = rr_ptr[req_index];
    sel_by_ptr = 1'b1;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (sel_by_ptr && !way_valid[w]) begin
        victim_sel = WAY_W'(w);
        sel_by_ptr = 1'b0;
      end
    end
  end

  always_comb begin
    state_next     = state;
    Ready          = 1'b0;
    Busy           = 1'b0;
    Instruction    = '0;
    MemReadRequest = 1'b0;
    MemReadAddress = '0;
    miss_latch     = 1'b0;
    invalidate     = 1'b0;
    fill_beat      = 1'b0;
    fill_last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (lookup_en) begin
          if (hit_any) begin
            Ready       = 1'b1;
            Instruction = hit_word;
          end else begin
            Busy       = 1'b1;
            miss_latch = 1'b1;
            state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        Busy           = 1'b1;
        MemReadRequest = 1'b1;
        MemReadAddress = line_base(32'(lat_tag), 32'(lat_index), OFF_W, IDX_W);
        invalidate     = 1'b1;
        state_next     = S_FILL;
      end
      S_FILL: begin
        Busy = 1'b1;
        if (MemDataReady) begin
          fill_beat = 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            fill_last  = 1'b1;
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        Ready       = 1'b1;
        Instruction = crit_word;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      lat_tag       <= '0;
      lat_index     <= '0;
      lat_offset    <= '0;
      victim        <= '0;
      victim_by_ptr <= 1'b0;
      beat_cnt      <= '0;
      crit_word     <= '0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        rr_ptr[s] <= '0;
      end
    end else begin
      state <= state_next;
      if (miss_latch) begin
        lat_tag       <= req_tag;
        lat_index     <= req_index;
        lat_offset    <= req_offset;
        victim        <= victim_sel;
        victim_by_ptr <= sel_by_ptr;
        beat_cnt      <= '0;
      end
      if (fill_beat) begin
        if (beat_cnt == lat_offset) begin
          crit_word <= MemDataIn;
        end
        beat_cnt <= beat_cnt + 1'b1;
        if (fill_last && victim_by_ptr) begin
          rr_ptr[lat_index] <= (NUM_WAYS > 1) ? WAY_W'(victim + 1'b1) : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154_icache.sv
module tb_ucsbece154_icache;

  localparam int LAT = 40;

  logic        clk;
  logic        reset;
  logic        ReadEnable;
  logic [31:0] ReadAddress;
  logic [31:0] Instruction;
  logic        Ready;
  logic        Busy;
  logic        MemReadRequest;
  logic [31:0] MemReadAddress;
  logic [31:0] MemDataIn;
  logic        MemDataReady;

  ucsbece154_icache #(
    .NUM_SETS    (8),
    .NUM_WAYS    (4),
    .BLOCK_WORDS (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ReadEnable     (ReadEnable),
    .ReadAddress    (ReadAddress),
    .Instruction    (Instruction),
    .Ready          (Ready),
    .Busy           (Busy),
    .MemReadRequest (MemReadRequest),
    .MemReadAddress (MemReadAddress),
    .MemDataIn      (MemDataIn),
    .MemDataReady   (MemDataReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned passed = 0;

  // Program text: each word is derived from its own address.
  function automatic logic [31:0] text_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- burst memory model ----------------
  logic        mem_active = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_beat = '0;
  logic [31:0] mem_base = '0;
  int          mem_cool = 0;
  logic        gap_mode = 1'b0;
  logic        gap_phase = 1'b0;
  logic        stray = 1'b0;
  int unsigned req_count = 0;
  int unsigned ignored = 0;
  int unsigned beats_sent = 0;
  int          last_final_cyc = -100;
  int          req_gap = 0;
  logic [31:0] last_req_addr = '0;

  initial begin : mem_model
    MemDataReady = 1'b0;
    MemDataIn    = '0;
    forever begin
      @(negedge clk);
      MemDataReady = 1'b0;
      MemDataIn    = '0;
      if (reset) begin
        mem_active = 1'b0;
        mem_cool   = 0;
      end else begin
        if (MemReadRequest) req_count++;
        if (mem_active) begin
          if (mem_wait > 0) mem_wait--;
          else if (gap_mode && gap_phase) gap_phase = 1'b0;
          else begin
            MemDataReady = 1'b1;
            MemDataIn    = text_at(mem_base + (mem_beat << 2));
            beats_sent++;
            gap_phase = 1'b1;
            if (mem_beat == 32'd3) begin
              mem_active     = 1'b0;
              mem_cool       = 1;
              last_final_cyc = cyc;
            end else begin
              mem_beat++;
            end
          end
        end else if (mem_cool > 0) begin
          mem_cool--;
          if (MemReadRequest) ignored++;
        end else if (MemReadRequest) begin
          mem_active    = 1'b1;
          mem_wait      = LAT;
          mem_beat      = '0;
          mem_base      = MemReadAddress;
          last_req_addr = MemReadAddress;
          req_gap       = cyc - last_final_cyc;
          beats_sent    = 0;
          gap_phase     = 1'b0;
        end else if (stray) begin
          MemDataReady = 1'b1;
          MemDataIn    = 32'hDEADBEEF;
        end
      end
    end
  end

  // ---------------- fetch driver ----------------
  logic in_done = 1'b0;

  task automatic fetch(input logic [31:0] a, output logic [31:0] instr,
                       output int unsigned reqs, output int unsigned lat,
                       output logic timeout);
    int unsigned r0;
    r0 = req_count;
    ReadEnable  = 1'b1;
    ReadAddress = a;
    if (in_done) begin
      @(negedge clk);
      #1;
    end
    #1;
    lat = 0;
    while (!Ready && lat < 400) begin
      @(negedge clk);
      #2;
      lat++;
      ReadAddress = a ^ 32'h00F0_0000;  // must be ignored while stalled
    end
    instr   = Instruction;
    timeout = !Ready;
    reqs    = req_count - r0;
    in_done = (lat != 0);
    if (lat == 0) begin
      @(negedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        miss;
    logic        gap;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs [18];

  initial begin : main
    logic [31:0] instr;
    int unsigned reqs, lat, w;
    logic        tmo;

    // addr, miss, gapped beats; set 0 holds tags 0x10000/080/100/180/200
    vecs[0]  = '{32'h0001_0004, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{32'h0001_0008, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{32'h0001_000C, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{32'h0001_0000, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{32'h0001_0080, 1'b1, 1'b1, 32'h0};
    vecs[5]  = '{32'h0001_0100, 1'b1, 1'b1, 32'h0};
    vecs[6]  = '{32'h0001_0180, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{32'h0001_0200, 1'b1, 1'b0, 32'h0};  // evicts way0, ptr->1
    vecs[8]  = '{32'h0001_0000, 1'b1, 1'b0, 32'h0};  // evicts way1, ptr->2
    vecs[9]  = '{32'h0001_0084, 1'b1, 1'b0, 32'h0};  // evicts way2, ptr->3
    vecs[10] = '{32'h0001_0188, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{32'h0001_0204, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{32'h0001_0004, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{32'h0001_0100, 1'b1, 1'b0, 32'h0};  // evicts way3, ptr->0
    vecs[14] = '{32'h0001_018C, 1'b1, 1'b0, 32'h0};  // evicts way0, ptr->1
    vecs[15] = '{32'h0001_0088, 1'b0, 1'b0, 32'h0};
    vecs[16] = '{32'h0001_0208, 1'b1, 1'b1, 32'h0};  // evicts way1, ptr->2
    vecs[17] = '{32'h0001_000C, 1'b1, 1'b0, 32'h0};  // evicts way2, ptr->3
    foreach (vecs[i]) vecs[i].exp_instr = text_at(vecs[i].addr);

    // Reset with a fetch pending: all outputs must stay zero.
    reset       = 1'b1;
    ReadEnable  = 1'b1;
    ReadAddress = 32'h0001_0004;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", {29'b0, Ready, Busy, MemReadRequest}, 32'h0);
    check("reset_instr", Instruction, 32'h0);
    check("reset_maddr", MemReadAddress, 32'h0);
    reset      = 1'b0;
    ReadEnable = 1'b0;
    @(negedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      gap_mode = vecs[i].gap;
      fetch(vecs[i].addr, instr, reqs, lat, tmo);
      check($sformatf("row%0d_timeout", i), {31'b0, tmo}, 32'h0);
      check($sformatf("row%0d_instr", i), instr, vecs[i].exp_instr);
      check($sformatf("row%0d_reqs", i), reqs, vecs[i].miss ? 32'd1 : 32'd0);
      if (vecs[i].miss)
        check($sformatf("row%0d_maddr", i), last_req_addr, vecs[i].addr & 32'hFFFF_FFF0);
      else
        check($sformatf("row%0d_latency", i), lat, 32'd0);
    end
    gap_mode = 1'b0;

    // Back-to-back misses: DONE and the IDLE miss cycle sit between the
    // final beat and the next request.
    fetch(32'h0001_0050, instr, reqs, lat, tmo);
    check("b2b_first_instr", instr, text_at(32'h0001_0050));
    fetch(32'h0001_0010, instr, reqs, lat, tmo);
    check("b2b_second_instr", instr, text_at(32'h0001_0010));
    check("b2b_second_reqs", reqs, 32'd1);
    check("b2b_req_gap", req_gap, 32'd3);
    check("mem_ignored_reqs", ignored, 32'd0);

    // Idle with stray memory beats.
    ReadEnable = 1'b0;
    if (in_done) begin
      @(negedge clk);
      #1;
      in_done = 1'b0;
    end
    stray = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      check($sformatf("idle%0d_ctrl", i), {29'b0, Ready, Busy, MemReadRequest}, 32'h0);
      check($sformatf("idle%0d_instr", i), Instruction, 32'h0);
    end
    stray = 1'b0;
    @(negedge clk);
    #1;
    fetch(32'h0001_0014, instr, reqs, lat, tmo);
    check("post_idle_instr", instr, text_at(32'h0001_0014));
    check("post_idle_reqs", reqs, 32'd0);

    // Reset after the second beat of a fill.
    beats_sent  = 0;
    ReadEnable  = 1'b1;
    ReadAddress = 32'h0001_0020;
    w = 0;
    while (beats_sent < 2 && w < 200) begin
      @(negedge clk);
      #2;
      w++;
    end
    check("midfill_beats_seen", {31'b0, beats_sent >= 2}, 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midfill_reset_ctrl", {29'b0, Ready, Busy, MemReadRequest}, 32'h0);
    check("midfill_reset_instr", Instruction, 32'h0);
    check("midfill_reset_maddr", MemReadAddress, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    reset   = 1'b0;
    in_done = 1'b0;
    fetch(32'h0001_0020, instr, reqs, lat, tmo);
    check("after_reset_instr", instr, text_at(32'h0001_0020));
    check("after_reset_reqs", reqs, 32'd1);
    check("after_reset_maddr", last_req_addr, 32'h0001_0020);
    fetch(32'h0001_0010, instr, reqs, lat, tmo);
    check("after_reset_cleared_reqs", reqs, 32'd1);
    check("after_reset_cleared_instr", instr, text_at(32'h0001_0010));

    ReadEnable = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
    $fatal(1);
  end

endmodule
